// File: rtl/sigmoid_arbiter.sv
// -----------------------------------------------------------------------------
// sigmoid_arbiter
//
// Shares one hard-sigmoid activation unit between N_REQ requesters. A
// round-robin arbiter picks one valid operand whenever the single-entry result
// register can accept, and the sigmoid of that operand is registered with the
// owner's index one cycle later. A completed-transfer counter tracks results
// handed downstream.
//
// Hard sigmoid (Q8.8 constants shown): Y = 0 for X < -2.0, Y = 1.0 for X > 2.0,
// otherwise Y = (X + 2.0) >>> 2.
//
// Ports
//   clk         : clock, all flops on rising edge
//   rst_n       : asynchronous active-low reset (deassertion synchronised)
//   req_valid   : [N_REQ]            per-requester operand valid
//   req_data    : [N_REQ*DATA_WIDTH] flattened signed operands, slot i at
//                                    [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   : [N_REQ]            one-hot combinational grant
//   out_valid   : result register holds a valid result
//   out_data    : [DATA_WIDTH]       signed sigmoid result
//   out_id      : [clog2(N_REQ)]     index of the requester owning out_data
//   out_ready   : downstream accepts the result
//   xfer_count  : [16]               completed output transfers, wraps
// -----------------------------------------------------------------------------
module sigmoid_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int N_REQ       = 4,   // legal range 2..8
  localparam int ID_WIDTH   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [ID_WIDTH-1:0]         out_id,
  input  logic                        out_ready,
  output logic [15:0]                 xfer_count
);

  // Sigmoid constants. TWO is the +2.0 bias; FOUR is the bias-shifted upper
  // clamp point (X > 2.0 <=> X + 2.0 > 4.0). Both live in the widened domain.
  localparam logic signed [DATA_WIDTH:0] TWO  = (DATA_WIDTH+1)'(1) << (FRACT_WIDTH + 1);
  localparam logic signed [DATA_WIDTH:0] FOUR = (DATA_WIDTH+1)'(1) << (FRACT_WIDTH + 2);
  localparam logic [DATA_WIDTH-1:0]      ONE  = DATA_WIDTH'(1) << FRACT_WIDTH;

  // State
  logic                  run_reg;        // low until one edge after rst_n rises
  logic [ID_WIDTH-1:0]   ptr_reg;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [ID_WIDTH-1:0]   out_id_reg;
  logic [15:0]           xfer_count_reg;

  logic [ID_WIDTH-1:0]   ptr_next;
  logic                  out_valid_next;
  logic [DATA_WIDTH-1:0] out_data_next;
  logic [ID_WIDTH-1:0]   out_id_next;
  logic [15:0]           xfer_count_next;

  // Arbitration / datapath
  logic                         accept;
  logic                         xfer;
  logic                         grant;
  logic                         found;
  logic [ID_WIDTH-1:0]          winner;
  int                           cand;
  logic signed [DATA_WIDTH-1:0] operand;
  logic signed [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0]        sig;

  assign accept = !out_valid_reg || out_ready;
  assign xfer   = out_valid_reg && out_ready;
  // run_reg gates grants so nothing is accepted during reset or on the first
  // edge after release; the first grant is captured on the second edge.
  assign grant  = run_reg && accept && found;

  // Round-robin search: walk offsets from the top down so the smallest offset
  // from ptr (the highest-priority valid requester) is the last one written.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr_reg) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (req_valid[cand]) begin
        found  = 1'b1;
        winner = ID_WIDTH'(cand);
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready[gi] = grant && (winner == ID_WIDTH'(gi));
  end

  // Hard sigmoid of the winner's operand. The bias is added one bit wider
  // than the operand so the clamp tests see the true sum, never a wrapped one.
  always_comb begin
    operand = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
    sum     = {operand[DATA_WIDTH-1], operand} + TWO;
    if (sum < 0) begin
      sig = '0;
    end else if (sum > FOUR) begin
      sig = ONE;
    end else begin
      sig = DATA_WIDTH'(sum >>> 2);
    end
  end

  // Next-state: a grant overwrites the result register even when the current
  // result is leaving this cycle, so back-to-back results have no bubble.
  always_comb begin
    ptr_next        = ptr_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_id_next     = out_id_reg;
    xfer_count_next = xfer ? xfer_count_reg + 16'd1 : xfer_count_reg;
    if (grant) begin
      ptr_next       = (winner == ID_WIDTH'(N_REQ - 1)) ? '0 : winner + ID_WIDTH'(1);
      out_valid_next = 1'b1;
      out_data_next  = sig;
      out_id_next    = winner;
    end else if (xfer) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg        <= 1'b0;
      ptr_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_id_reg     <= '0;
      xfer_count_reg <= '0;
    end else begin
      run_reg        <= 1'b1;
      ptr_reg        <= ptr_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_id_reg     <= out_id_next;
      xfer_count_reg <= xfer_count_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_id     = out_id_reg;
  assign xfer_count = xfer_count_reg;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_arbiter
//
// Directed test of sigmoid_arbiter (N_REQ=4, Q8.8): reset values, first grant
// after reset release, sigmoid boundary values, round-robin order and skipping,
// back-pressure hold, asynchronous reset mid-stream and xfer_count wrap.
// Inputs change 1 time unit after the rising edge; outputs are checked there
// or after a further 1 time unit of settling.
// -----------------------------------------------------------------------------
module tb_sigmoid_arbiter;

  localparam int DW  = 16;
  localparam int NR  = 4;
  localparam int IDW = 2;

  logic               clk;
  logic               rst_n;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [IDW-1:0]     out_id;
  logic               out_ready;
  logic [15:0]        xfer_count;

  int   n_checks;
  int   n_fail;
  logic exp_valid;
  int   exp_xfer;

  sigmoid_arbiter #(
    .DATA_WIDTH (DW),
    .FRACT_WIDTH(8),
    .N_REQ      (NR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .xfer_count(xfer_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock. The expected result-register state is updated from
  // the stimulus: g says whether a grant is expected in the cycle just ending.
  task automatic tick(input logic g);
    if (exp_valid && out_ready) exp_xfer++;
    if (g) exp_valid = 1'b1;
    else if (exp_valid && out_ready) exp_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Sigmoid boundary operands and their hand-computed results.
  logic [15:0] bx [6] = '{16'h8000, 16'hFE00, 16'hFDFF, 16'h0200, 16'h0201, 16'h7FFF};
  logic [15:0] by [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0100};
  // Per-requester operands for round robin: 0, 1.0, -1.0, 4.0
  logic [15:0] rx [4] = '{16'h0000, 16'h0100, 16'hFF00, 16'h0400};
  logic [15:0] ry [4] = '{16'h0080, 16'h00C0, 16'h0040, 16'h0100};
  int          skip_w [3] = '{1, 3, 1};

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_valid = 1'b0;
    exp_xfer  = 0;
    rst_n     = 1'b1;
    req_valid = '1;
    req_data  = '0;
    out_ready = 1'b0;

    // ---------------- reset state
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    check_eq("rst_data",  32'(out_data),  32'h0);
    check_eq("rst_id",    32'(out_id),    32'h0);
    check_eq("rst_xfer",  32'(xfer_count), 32'h0);

    // ---------------- release, single requester 0 with X=0
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 4'b0001;
    req_data  = '0;
    out_ready = 1'b1;
    #1;
    check_eq("sync_no_grant", 32'(req_ready), 32'h0);
    tick(1'b0);
    check_eq("x0_ready", 32'(req_ready), 32'h1);
    check_eq("x0_pre_valid", 32'(out_valid), 32'h0);
    tick(1'b1);
    check_eq("x0_valid", 32'(out_valid), 32'h1);
    check_eq("x0_data",  32'(out_data),  32'h0080);
    check_eq("x0_id",    32'(out_id),    32'h0);
    $display("xfer id=%0d data=0x%04h", out_id, out_data);
    req_valid = '0;
    tick(1'b0);
    check_eq("drain_valid", 32'(out_valid), 32'h0);
    check_eq("drain_xfer",  32'(xfer_count), 32'(exp_xfer));

    // ---------------- sigmoid boundaries, rotating requester (ends with ptr=0)
    for (int i = 0; i < 6; i++) begin
      int r;
      r = (i + 2) % 4;
      req_data = '0;
      req_data[r*DW +: DW] = bx[i];
      req_valid = NR'(1) << r;
      #1;
      check_eq($sformatf("bnd%0d_ready", i), 32'(req_ready), 32'(NR'(1) << r));
      tick(1'b1);
      check_eq($sformatf("bnd%0d_data", i), 32'(out_data), 32'(by[i]));
      check_eq($sformatf("bnd%0d_id", i),   32'(out_id),   32'(r));
      $display("xfer id=%0d x=0x%04h y=0x%04h", out_id, bx[i], out_data);
    end

    // ---------------- all requesters valid: 0,1,2,3,0,...
    for (int k = 0; k < 4; k++) req_data[k*DW +: DW] = rx[k];
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      check_eq($sformatf("rr%0d_ready", c), 32'(req_ready), 32'(NR'(1) << (c % 4)));
      tick(1'b1);
      check_eq($sformatf("rr%0d_id", c),    32'(out_id),   32'(c % 4));
      check_eq($sformatf("rr%0d_data", c),  32'(out_data), 32'(ry[c % 4]));
      $display("xfer id=%0d data=0x%04h", out_id, out_data);
    end
    check_eq("rr_xfer", 32'(xfer_count), 32'(exp_xfer));

    // ---------------- sparse requests: round robin skips idle requesters
    req_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq($sformatf("skip%0d_ready", c), 32'(req_ready), 32'(NR'(1) << skip_w[c]));
      tick(1'b1);
      check_eq($sformatf("skip%0d_id", c), 32'(out_id), 32'(skip_w[c]));
      $display("xfer id=%0d data=0x%04h", out_id, out_data);
    end

    // ---------------- back-pressure for 5 cycles (ptr=2, requester 1 pending)
    out_ready = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq($sformatf("bp%0d_ready", c), 32'(req_ready), 32'h0);
      tick(1'b0);
      check_eq($sformatf("bp%0d_valid", c), 32'(out_valid), 32'h1);
      check_eq($sformatf("bp%0d_id", c),    32'(out_id),    32'h1);
      check_eq($sformatf("bp%0d_data", c),  32'(out_data),  32'h00C0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(req_ready), 32'h4);
    tick(1'b1);
    check_eq("bp_release_id",   32'(out_id),   32'h2);
    check_eq("bp_release_data", 32'(out_data), 32'h0040);
    check_eq("bp_release_xfer", 32'(xfer_count), 32'(exp_xfer));
    $display("xfer id=%0d data=0x%04h", out_id, out_data);
    req_valid = '0;
    tick(1'b0);

    // ---------------- async reset with a result pending
    req_valid = 4'b0001;
    out_ready = 1'b0;
    tick(1'b1);
    check_eq("pend_valid", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(out_valid),  32'h0);
    check_eq("arst_xfer",  32'(xfer_count), 32'h0);
    check_eq("arst_data",  32'(out_data),   32'h0);
    check_eq("arst_id",    32'(out_id),     32'h0);
    check_eq("arst_ready", 32'(req_ready),  32'h0);
    exp_valid = 1'b0;
    exp_xfer  = 0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("arst_sync_ready", 32'(req_ready), 32'h0);
    tick(1'b0);
    check_eq("arst_first_ready", 32'(req_ready), 32'h1);
    tick(1'b1);
    check_eq("arst_first_id", 32'(out_id), 32'h0);
    $display("xfer id=%0d data=0x%04h", out_id, out_data);

    // ---------------- xfer_count wrap
    while (exp_xfer < 65535) tick(1'b1);
    check_eq("xfer_ffff", 32'(xfer_count), 32'hFFFF);
    tick(1'b1);
    check_eq("xfer_wrap", 32'(xfer_count), 32'h0000);
    check_eq("xfer_wrap_valid", 32'(out_valid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sigmoid_arbiter.md
SIGMOID_ARBITER -- requirements
Module: sigmoid_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sets the width of every data operand (signed fixed point).
REQ-002 Parameter FRACT_WIDTH, default 8, sets the number of fractional bits; constants below are for Q8.8.
REQ-003 Parameter N_REQ, default 4, sets the number of requesters sharing the activation unit; the legal range is 2..8.
REQ-004 Port clk, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port req_valid, input, N_REQ bits: per-requester operand valid.
REQ-007 Port req_data, input, N_REQ*DATA_WIDTH bits: flattened signed operands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port req_ready, output, N_REQ bits: one-hot grant, asserted combinationally in the cycle requester i is accepted.
REQ-009 Port out_valid, output, 1 bit: the result register holds a valid result.
REQ-010 Port out_data, output, DATA_WIDTH bits: signed sigmoid result.
REQ-011 Port out_id, output, clog2(N_REQ) bits: index of the requester that owns out_data.
REQ-012 Port out_ready, input, 1 bit: downstream consumer accepts the result.
REQ-013 Port xfer_count, output, 16 bits: count of completed output transfers, wrapping modulo 2^16.

Function
REQ-014 The block SHALL compute a hard sigmoid: if X < -0x0200, Y = 0x0000; if X > 0x0200, Y = 0x0100; otherwise Y = (X + 0x0200) >>> 2 (arithmetic shift).
REQ-015 The sum X + 0x0200 SHALL be formed at DATA_WIDTH+1 bits so the clamp decision never depends on a wrapped sum.
REQ-016 The result register SHALL have an accept slot, defined as accept = !out_valid || out_ready.
REQ-017 When accept is high and any req_valid bit is set, exactly one req_ready bit SHALL assert, chosen by the round-robin rule in REQ-018.
REQ-018 Round-robin rule: the search starts at index ptr and wraps modulo N_REQ; the first index with req_valid set wins.
REQ-019 When accept is low, or no req_valid bit is set, req_ready SHALL be all zeros.
REQ-020 ptr SHALL load (winner+1) mod N_REQ on each grant and SHALL otherwise hold.
REQ-021 On a grant, the next edge SHALL load out_data with the sigmoid of the winner's operand, load out_id with the winner index, and set out_valid (latency one cycle).
REQ-022 If out_valid && out_ready and there is no grant, out_valid SHALL clear on the next edge.
REQ-023 If out_valid && out_ready and there is a grant in the same cycle, the register SHALL be overwritten with no bubble, so throughput is one result per cycle.
REQ-024 While out_valid && !out_ready, out_data and out_id SHALL hold stable and req_ready SHALL stay all zeros.
REQ-025 xfer_count SHALL increment on every cycle with out_valid && out_ready, and SHALL wrap from 0xFFFF to 0x0000.
REQ-026 A requester SHALL NOT be granted in any cycle where its req_valid is low.
REQ-027 Starvation bound: a requester that holds req_valid high SHALL be granted within N_REQ grants.
REQ-028 If N_REQ is not a power of two, out_id values of N_REQ and above SHALL never appear.

Reset
REQ-029 Asserting rst_n low SHALL immediately clear out_valid, out_data, out_id, ptr and xfer_count to 0, independent of clk.
REQ-030 While rst_n is low, req_ready SHALL be all zeros.
REQ-031 A reset asserted while a result is pending SHALL discard that result, and SHALL not count it in xfer_count.
REQ-032 Deassertion of rst_n SHALL be synchronised internally; the first grant SHALL be possible on the second rising edge after rst_n rises.

Verification
REQ-033 Single requester 0 with X=0x0000, out_ready=1 -> req_ready=0001 the same cycle; next cycle out_valid=1, out_data=0x0080, out_id=0.
REQ-034 Boundary values X = 0x8000, 0xFE00, 0xFDFF, 0x0200, 0x0201, 0x7FFF -> Y = 0x0000, 0x0000, 0x0000, 0x0100, 0x0100, 0x0100.
REQ-035 All four requesters valid continuously with out_ready=1 -> grants in order 0,1,2,3,0,...; one result per cycle; out_id follows the grant order delayed by one cycle.
REQ-036 out_ready held at 0 for 5 cycles with a result pending -> out_data and out_id stable, req_ready=0; after out_ready rises, the pending result transfers and the next grant occurs in the same cycle.
REQ-037 rst_n pulsed low mid-stream with out_valid=1 and xfer_count=7 -> out_valid=0 and xfer_count=0 immediately; after release, the first grant goes to requester 0.
REQ-038 65536 transfers -> xfer_count wraps to 0x0000.
